sim_end_monitor: RTL

- Synthesizable, parametrised end-of-test monitor that replaces ad-hoc halt detection in benches.
- Watches the decode-stage instruction stream and a tohost-style result write port, counts cycles and accepted instructions, and enforces a timeout watchdog.
- Raises sticky done/pass/fail/timeout flags after a configurable drain delay.
- Instantiated beside top in every bench; the bench calls $finish on done.

---
 rtl/sim_end_monitor.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sim_end_monitor.sv
// rtl/sim_end_monitor.sv - end-of-test monitor: halt/tohost/watchdog detection with sticky verdict flags
module sim_end_monitor #(
    parameter int          XLEN           = 32,
    parameter logic [31:0] HALT_INSN      = 32'h00002013,
    parameter int          DRAIN_CYCLES   = 5,
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             insn_valid,
    input  logic             insn_stall,
    input  logic [31:0]      insn,
    input  logic             tohost_we,
    input  logic [XLEN-1:0]  tohost_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timed_out,
    output logic [XLEN-2:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] insn_count
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int               DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam bit               DRAIN_NONE   = (DRAIN_CYCLES == 0);
    localparam bit               WDOG_EN      = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    logic [1:0]         state;
    logic [1:0]         state_d;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [DRAIN_W-1:0] drain_cnt_d;
    logic               done_d;
    logic               pass_d;
    logic               fail_d;
    logic               timed_out_d;
    logic [XLEN-2:0]    fail_code_d;
    logic [CNT_W-1:0]   cycle_count_d;
    logic [CNT_W-1:0]   insn_count_d;

    logic active;
    logic accept;
    logic halt_accept;
    logic halt_end;
    logic drain_end;
    logic tohost_hit;
    logic tohost_pass;
    logic wdog_hit;

    assign active      = (state == ST_RUN) || (state == ST_DRAIN);
    assign accept      = insn_valid && !insn_stall;
    assign halt_accept = (state == ST_RUN) && accept && (insn == HALT_INSN);
    assign halt_end    = halt_accept && DRAIN_NONE;
    assign drain_end   = (state == ST_DRAIN) && (drain_cnt == DRAIN_W'(1));
    assign tohost_hit  = active && tohost_we && (tohost_data != '0);
    assign tohost_pass = (tohost_data == XLEN'(1));
    assign wdog_hit    = WDOG_EN && active && (cycle_count == TIMEOUT_LAST);

    // Verdict priority: tohost, then halt/drain completion, then halt entering drain, then watchdog.
    always_comb begin
        state_d     = state;
        drain_cnt_d = drain_cnt;
        done_d      = done;
        pass_d      = pass;
        fail_d      = fail;
        timed_out_d = timed_out;
        fail_code_d = fail_code;
        if (tohost_hit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (tohost_pass) begin
                pass_d = 1'b1;
            end else begin
                fail_d      = 1'b1;
                fail_code_d = tohost_data[XLEN-1:1];
            end
        end else if (halt_end || drain_end) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
        end else if (halt_accept) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
        end else if (wdog_hit) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            timed_out_d = 1'b1;
        end else if (state == ST_DRAIN) begin
            drain_cnt_d = drain_cnt - DRAIN_W'(1);
        end
    end

    // Counters saturate so a runaway bench never reports a wrapped, misleading count.
    always_comb begin
        cycle_count_d = cycle_count;
        insn_count_d  = insn_count;
        if (active && (cycle_count != CNT_MAX)) begin
            cycle_count_d = cycle_count + CNT_W'(1);
        end
        if ((state == ST_RUN) && accept && (insn_count != CNT_MAX)) begin
            insn_count_d = insn_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timed_out   <= 1'b0;
            fail_code   <= '0;
            cycle_count <= '0;
            insn_count  <= '0;
        end else begin
            state       <= state_d;
            drain_cnt   <= drain_cnt_d;
            done        <= done_d;
            pass        <= pass_d;
            fail        <= fail_d;
            timed_out   <= timed_out_d;
            fail_code   <= fail_code_d;
            cycle_count <= cycle_count_d;
            insn_count  <= insn_count_d;
        end
    end

endmodule
